dcfifo_s_reader: RTL

Read-side adapter for a normal-mode `dcfifo_s`, running entirely in the FIFO's read clock domain. It issues `rdreq` whenever the FIFO is non-empty and local space exists, and aligns `q` to the configured read latency. It captures words into a small internal buffer and presents them as a valid/ready stream. It sustains one word per cycle with no combinational path from `out_ready` to `rdreq`.

---
 rtl/dcfifo_s_reader_if.sv | 30 +++
 rtl/dcfifo_s_reader.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/dcfifo_s_reader_if.sv
// dcfifo_s_reader_if: FIFO read-port signals plus the valid/ready output stream.
// The slave modport is the reader's view; the master modport drives the reader.
interface dcfifo_s_reader_if #(
   parameter int WIDTH = 20
);
   logic             rdempty;
   logic [WIDTH-1:0] q;
   logic             rdreq;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport master (
      output rdempty,
      output q,
      input  rdreq,
      input  out_valid,
      output out_ready,
      input  out_data
   );

   modport slave (
      input  rdempty,
      input  q,
      output rdreq,
      output out_valid,
      input  out_ready,
      output out_data
   );
endinterface

// File: rtl/dcfifo_s_reader.sv
// dcfifo_s_reader: read-side adapter for a normal-mode dcfifo_s, entirely in the rdclk domain.
// Optional macro DCFIFO_S_READER_CNT_EN adds words_out, a wrapping count of accepted words.
module dcfifo_s_reader #(
   parameter int WIDTH      = 20,
   parameter int RD_LATENCY = 1
) (
   input  logic             rdclk,
   input  logic             sclr,
   dcfifo_s_reader_if.slave bus
`ifdef DCFIFO_S_READER_CNT_EN
   ,
   output logic [31:0]      words_out
`endif
);
   localparam int BUF_DEPTH = RD_LATENCY + 2;
   localparam int PTR_W     = $clog2(BUF_DEPTH);
   localparam int OCC_W     = $clog2(BUF_DEPTH + 1);
   localparam int SUM_W     = OCC_W + 1;

   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(BUF_DEPTH - 1);
   localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
   localparam logic [OCC_W-1:0] OCC_ZERO  = {OCC_W{1'b0}};
   localparam logic [OCC_W-1:0] OCC_ONE   = OCC_W'(1);
   localparam logic [SUM_W-1:0] DEPTH_SUM = SUM_W'(BUF_DEPTH);

   // Pointers wrap at BUF_DEPTH, which is generally not a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      logic [PTR_W-1:0] r;
      if (p == PTR_LAST) begin
         r = PTR_ZERO;
      end else begin
         r = p + PTR_W'(1);
      end
      return r;
   endfunction

   function automatic logic [SUM_W-1:0] popcount(input logic [RD_LATENCY-1:0] v);
      logic [SUM_W-1:0] n;
      n = {SUM_W{1'b0}};
      for (int i = 0; i < RD_LATENCY; i++) begin
         n = n + SUM_W'(v[i]);
      end
      return n;
   endfunction

   logic [WIDTH-1:0]      mem_q [BUF_DEPTH];
   logic [OCC_W-1:0]      occ_q, occ_d;
   logic [RD_LATENCY-1:0] inflight_q, inflight_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic                  out_valid_q, out_valid_d;
   logic [WIDTH-1:0]      out_data_q, out_data_d;

   logic                  capture_s;
   logic                  pop_s;
   logic                  rdreq_s;

   // Credit check uses registered state only; a same-cycle pop is deliberately not credited.
   assign capture_s = inflight_q[RD_LATENCY-1];
   assign pop_s     = out_valid_q & bus.out_ready;
   assign rdreq_s   = ~sclr & ~bus.rdempty &
                      ((SUM_W'(occ_q) + popcount(inflight_q)) < DEPTH_SUM);

   // Next-state for pointers, occupancy, in-flight tracking and the registered head.
   always_comb begin
      inflight_d    = {RD_LATENCY{1'b0}};
      inflight_d[0] = rdreq_s;
      for (int i = 1; i < RD_LATENCY; i++) begin
         inflight_d[i] = inflight_q[i-1];
      end

      if (capture_s) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({capture_s, pop_s})
         2'b10:   occ_d = occ_q + OCC_ONE;
         2'b01:   occ_d = occ_q - OCC_ONE;
         default: occ_d = occ_q;
      endcase

      out_valid_d = (occ_d != OCC_ZERO);

      // A word written this cycle into the next head slot must reach out_data next cycle.
      if (capture_s && (wr_ptr_q == rd_ptr_d)) begin
         out_data_d = bus.q;
      end else begin
         out_data_d = mem_q[rd_ptr_d];
      end
   end

   // State registers with synchronous clear.
   always_ff @(posedge rdclk) begin
      if (sclr) begin
         occ_q       <= OCC_ZERO;
         inflight_q  <= {RD_LATENCY{1'b0}};
         rd_ptr_q    <= PTR_ZERO;
         wr_ptr_q    <= PTR_ZERO;
         out_valid_q <= 1'b0;
         out_data_q  <= {WIDTH{1'b0}};
         for (int i = 0; i < BUF_DEPTH; i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
      end else begin
         occ_q       <= occ_d;
         inflight_q  <= inflight_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         if (capture_s) begin
            mem_q[wr_ptr_q] <= bus.q;
         end
      end
   end

   assign bus.rdreq     = rdreq_s;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;

`ifdef DCFIFO_S_READER_CNT_EN
   logic [31:0] words_q;

   // Accepted-word counter; wraps naturally at 32 bits.
   always_ff @(posedge rdclk) begin
      if (sclr) begin
         words_q <= 32'h0000_0000;
      end else if (pop_s) begin
         words_q <= words_q + 32'h0000_0001;
      end
   end

   assign words_out = words_q;
`endif
endmodule
